// File: rtl/aes_gate_pkg.sv
// Shared types and constants for the AES result gate.
package aes_gate_pkg;

  localparam int AES_BLK_W              = 128;
  localparam int GATE_DEF_LOCK_THRESHOLD = 3;
  localparam int GATE_DEF_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } gate_state_e;

endpackage

// File: rtl/aes_event_edge.sv
// Rising-edge detector: turns a level into a single-cycle event.
// Latency: combinational event, one register of history; no backpressure.
module aes_event_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic evt_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign evt_o = sig_i & ~sig_q;

endmodule

// File: rtl/aes_result_gate.sv
// Releases matched AES ciphertext over valid/ready, counts faults, locks out at threshold; out_valid 1 clk after event.
// Backpressure: held result stays stable until out_ready; new results arriving while stalled are dropped and flag overrun.
// Optional AES_GATE_RETRY_EN: pulse retry_req alongside fault_irq for non-locking faults.
module aes_result_gate
  import aes_gate_pkg::*;
#(
  parameter int LOCK_THRESHOLD = GATE_DEF_LOCK_THRESHOLD,
  parameter int CNT_W          = GATE_DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aes_valid,
  input  logic                 aes_fault_alert,
  input  logic [AES_BLK_W-1:0] aes_ciphertext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [CNT_W-1:0]     fault_count,
  output logic                 fault_irq,
  output logic                 overrun,
  output logic                 locked,
  output logic                 retry_req
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_THRESHOLD);

  gate_state_e          state_q, state_d;
  logic [AES_BLK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                 irq_q, irq_d;
  logic                 ovr_q, ovr_d;
  logic                 valid_raw, fault_evt, valid_evt;
  logic                 lock_now;

  aes_event_edge u_valid_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (aes_valid),
    .evt_o (valid_raw)
  );

  aes_event_edge u_fault_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (aes_fault_alert),
    .evt_o (fault_evt)
  );

  // A simultaneous fault disqualifies the matched result.
  assign valid_evt = valid_raw & ~fault_evt;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign lock_now  = fault_evt && (state_q != LOCKED) && (cnt_inc >= LOCK_TH);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (valid_evt) begin
          data_d  = aes_ciphertext;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (valid_evt) begin
            data_d = aes_ciphertext;
          end else begin
            data_d  = '0;
            state_d = IDLE;
          end
        end else if (valid_evt) begin
          ovr_d = 1'b1;
        end
      end
      LOCKED: begin
      end
      default: begin
        data_d  = '0;
        state_d = LOCKED;
      end
    endcase
    if (fault_evt && (state_q == IDLE || state_q == HOLD)) begin
      cnt_d = cnt_inc;
      irq_d = 1'b1;
      if (lock_now) begin
        state_d = LOCKED;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef AES_GATE_RETRY_EN
  logic retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= 1'b0;
    else        retry_q <= fault_evt && (state_q == IDLE || state_q == HOLD) && !lock_now;
  end

  assign retry_req = retry_q;
`else
  assign retry_req = 1'b0;
`endif

  assign out_valid   = (state_q == HOLD);
  assign out_data    = data_q;
  assign fault_count = cnt_q;
  assign fault_irq   = irq_q;
  assign overrun     = ovr_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: doc/aes_result_gate.md
Name: aes_result_gate

Overview:
Output stage directly downstream of the hardened AES top. Detects completed-encryption and fault events from the duplicated-core comparator. Releases good ciphertext to the consumer over a valid/ready handshake, and zeroises data when not presented. Counts faults and locks the output permanently (until reset) once a threshold is reached.

Parameters:
LOCK_THRESHOLD, 3, number of fault events that forces lockout; legal range 1 .. 2**CNT_W-1.
CNT_W, 4, width of the saturating fault counter.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
aes_valid  input  1  level from AES top: results matched
aes_fault_alert  input  1  level from AES top: results mismatched
aes_ciphertext  input  128  ciphertext from AES top, sampled on valid event
out_valid  output  1  result available to consumer
out_ready  input  1  consumer accepts result
out_data  output  128  held ciphertext; all-zero whenever out_valid=0
fault_count  output  CNT_W  saturating count of fault events since reset
fault_irq  output  1  one-cycle pulse per counted fault event
overrun  output  1  sticky: a valid event was dropped while holding
locked  output  1  lockout active
retry_req  output  1  one-cycle re-encrypt request (feature only)

Behaviour:
- Reset (async assert, sync deassert by system): out_valid=0, out_data=0, fault_count=0, fault_irq=0, overrun=0, locked=0, retry_req=0, state=IDLE, edge registers=0.
- Events are rising edges: valid_evt = aes_valid & ~aes_valid_q; fault_evt = aes_fault_alert & ~aes_fault_q. Level inputs held high produce one event only.
- If valid_evt and fault_evt occur in the same cycle, fault_evt wins and valid_evt is discarded.
- FSM states: IDLE, HOLD, LOCKED.
- IDLE + valid_evt: capture aes_ciphertext, go to HOLD. out_valid rises the next cycle (latency 1 clk from event).
- HOLD: out_valid=1, out_data stable until handshake.
  - out_ready=1 with no new valid_evt: go to IDLE and clear out_data to 0 in the same edge.
  - out_ready=1 with valid_evt: capture the new data and stay in HOLD (back-to-back, no bubble).
  - out_ready=0 with valid_evt: new data is dropped, overrun is set (sticky until reset), held data is unchanged.
- fault_evt in IDLE or HOLD: fault_count increments (saturates at 2**CNT_W-1), and fault_irq pulses the next cycle.
  - If the new count >= LOCK_THRESHOLD: go to LOCKED next cycle, clear out_data, drop out_valid. An in-flight held result is discarded without a handshake.
  - Otherwise state and held data are unchanged.
- LOCKED: locked=1, out_valid=0, out_data=0. All events are ignored and the counter is frozen. Only exit is rst_n.
- Reset mid-HOLD: result is lost and out_data is zero immediately (asynchronous).
- The consumer must not see out_data change while out_valid=1 and out_ready=0.

Optional Feature:
Macro AES_GATE_RETRY_EN.
- Defined: a fault_evt that does not cause lockout pulses retry_req for one cycle, aligned with fault_irq. The system uses it to re-issue start.
- Not defined: retry_req is tied to 0 and no retry logic is present.

Decomposition:
- Package aes_gate_pkg holds:
  - state enum gate_state_e {IDLE, HOLD, LOCKED}
  - localparam AES_BLK_W = 128
  - default LOCK_THRESHOLD and CNT_W constants
- One sub-module: aes_event_edge, a rising-edge detector. Instantiated twice, once for aes_valid and once for aes_fault_alert.

Test Plan:
- Reset, then aes_valid pulse with aes_ciphertext=128'h3925841d02dc09fbdc118597196a0b32 and out_ready=0 -> out_valid=1 one cycle later with that data; raise out_ready -> out_valid=0 and out_data=0 next cycle.
- aes_valid held high 10 cycles, out_ready=1 -> exactly one transfer.
- In HOLD with out_ready=0, second aes_valid edge with data 128'h1 -> out_data keeps first value, overrun=1.
- Three aes_fault_alert edges (LOCK_THRESHOLD=3) -> fault_irq three times, fault_count=3, locked=1; then an aes_valid edge -> out_valid stays 0, out_data stays 0.
- aes_valid and aes_fault_alert rising together -> no capture, fault_count=1; with AES_GATE_RETRY_EN, retry_req pulses once.
- rst_n asserted while in HOLD -> out_valid, out_data and locked all 0 immediately; after release, normal capture works.
